jms_serial_rx: RTL and testbench

Receiver for the team's single-wire framed serial test link. It samples the line on bit-enable strobes, tracks the frame with a small state machine, and checks parity and stop bit. Good frames are delivered as parallel words through a one-entry valid/ready holding register. It is the receiving end of the serial launch path built from the team's registered flip-flop cells, and it serves as a sequential target for netlist fault-injection campaigns.

---
 rtl/jms_serial_rx.sv | 118 +++++++++++
 tb/tb_jms_serial_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jms_serial_rx.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Good frames are delivered through a one-entry valid/ready holding register with sticky errors.
module jms_serial_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             rx,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StBreak} state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par;

  logic pop, par_ok, stop_ok, accept, take;

  always_comb begin
    pop     = out_valid & out_ready;
    par_ok  = (PARITY_EN == 0) || !par;
    stop_ok = bit_en && (state == StStop) && rx;
    accept  = stop_ok && par_ok;
    // A pop in the same cycle frees the holding register for the new word.
    take    = accept && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Clears come first so that a simultaneous set below wins.
      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end

      if (take) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (accept && !take) overrun <= 1'b1;
      if (stop_ok && !par_ok) parity_err <= 1'b1;

      if (bit_en) begin
        unique case (state)
          StIdle: begin
            if (!rx) begin
              state <= StData;
              cnt   <= '0;
              par   <= 1'b0;
              busy  <= 1'b1;
            end
          end
          StData: begin
            shreg[cnt] <= rx;
            par        <= par ^ rx;
            if (cnt == LastBit) begin
              state <= (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          StParity: begin
            par   <= par ^ rx;
            state <= StStop;
          end
          StStop: begin
            if (rx) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= StBreak;
            end
          end
          StBreak: begin
            if (rx) begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jms_serial_rx.sv
// Directed bench for jms_serial_rx (WIDTH=8, even parity): table of single frames plus
// hand-written sequences for framing break, overrun, sparse strobes and mid-frame reset.
module tb_jms_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n, bit_en, rx, out_ready, err_clr;
  logic [7:0] out_data;
  logic       out_valid, parity_err, frame_err, overrun, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jms_serial_rx #(.WIDTH(8), .PARITY_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .rx        (rx),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One bit_en strobe carrying line value b, followed by gap-1 idle cycles.
  task automatic strobe(input logic b, input int gap);
    @(negedge clk);
    rx     = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    rx     = 1'b1;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    strobe((^d) ^ flip, gap);
    strobe(stop, gap);
  endtask

  task automatic cleanup();
    @(negedge clk);
    out_ready = 1'b1;
    err_clr   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    err_clr   = 1'b0;
    strobe(1'b1, 1);
  endtask

  initial begin
    rst_n = 1'b0; bit_en = 1'b0; rx = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset flags", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{data: 8'hA5, par_flip: 1'b0, stop: 1'b1, exp_valid: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA5, par_flip: 1'b1, stop: 1'b1, exp_valid: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h3C, par_flip: 1'b0, stop: 1'b0, exp_valid: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[3] = '{data: 8'hFF, par_flip: 1'b0, stop: 1'b1, exp_valid: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h00, par_flip: 1'b0, stop: 1'b1, exp_valid: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop, 1);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) check($sformatf("vec%0d out_data", v), 32'(out_data), 32'(vecs[v].data));
      check($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
      check($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d overrun", v), 32'(overrun), 32'h0);
      cleanup();
      @(negedge clk);
      check($sformatf("vec%0d cleared", v),
            {28'h0, out_valid, parity_err, frame_err, overrun}, 32'h0);
      check($sformatf("vec%0d idle", v), 32'(busy), 32'h0);
    end

    // Framing error, line held low, then recovery to a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    @(negedge clk);
    check("brk frame_err", 32'(frame_err), 32'h1);
    check("brk busy after stop", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1);
      @(negedge clk);
      check($sformatf("brk busy low%0d", i), 32'(busy), 32'h1);
    end
    strobe(1'b1, 1);
    @(negedge clk);
    check("brk busy released", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    @(negedge clk);
    check("brk next valid", 32'(out_valid), 32'h1);
    check("brk next data", 32'(out_data), 32'h5A);
    check("brk frame_err sticky", 32'(frame_err), 32'h1);
    cleanup();

    // Overrun, then a frame completing on the cycle the full register is popped.
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    @(negedge clk);
    check("ovr data held", 32'(out_data), 32'h11);
    check("ovr valid", 32'(out_valid), 32'h1);
    check("ovr flag", 32'(overrun), 32'h1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr cleared", 32'(overrun), 32'h0);
    check("ovr valid kept", 32'(out_valid), 32'h1);
    strobe(1'b0, 1);
    for (int i = 0; i < 8; i++) strobe(logic'((8'h33 >> i) & 8'h1), 1);
    strobe(^8'h33, 1);
    out_ready = 1'b1;
    strobe(1'b1, 1);
    out_ready = 1'b0;
    @(negedge clk);
    check("pop+load data", 32'(out_data), 32'h33);
    check("pop+load valid", 32'(out_valid), 32'h1);
    check("pop+load overrun", 32'(overrun), 32'h0);
    cleanup();

    // Strobe every third cycle.
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    check("sparse valid early", 32'(out_valid), 32'h1);
    @(negedge clk);
    check("sparse valid", 32'(out_valid), 32'h1);
    check("sparse data", 32'(out_data), 32'h5A);
    check("sparse flags", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    cleanup();

    // Leave a word and a flag pending, then reset in the middle of a frame.
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    strobe(1'b0, 1);
    for (int i = 0; i < 4; i++) strobe(logic'((8'h81 >> i) & 8'h1), 1);
    check("pre-rst busy", 32'(busy), 32'h1);
    check("pre-rst valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst flags", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 1);
    @(negedge clk);
    check("post-rst valid", 32'(out_valid), 32'h1);
    check("post-rst data", 32'(out_data), 32'h81);
    check("post-rst flags", {29'h0, parity_err, frame_err, overrun}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
